// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed driver for an N-digit common-anode
// seven-segment display with per-digit decimal point, blink and optional
// leading-zero suppression. Inputs are shadowed once per scan frame.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   digits      nibble i at [4i+3:4i], digit 0 is rightmost (an[0])
//   dp          per-digit decimal point enable
//   blink_mask  per-digit blink enable
//   lz_en       leading-zero suppression enable
//   seg         active-low segments {dp,g,f,e,d,c,b,a}
//   an          active-low one-hot digit enable
//   frame_tick  one-cycle pulse in the cycle after the shadow registers load
module seven_seg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64,
  parameter int HEX_EN       = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_en,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FRAMES - 1);

  logic [RW-1:0]           refresh_cnt;
  logic [IW-1:0]           idx;
  logic [BW-1:0]           blink_cnt;
  logic                    blink_phase;
  logic                    loaded;
  logic [4*NUM_DIGITS-1:0] sh_digits;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blink;
  logic                    sh_lz_en;

  logic                    frame_start;
  logic                    ref_wrap;
  logic [NUM_DIGITS-1:0]   lz;
  logic                    zero_above;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blink;
  logic                    cur_lz;
  logic [6:0]              cur_dec;
  logic [NUM_DIGITS-1:0]   an_sel;

  assign ref_wrap    = (refresh_cnt == REF_LAST);
  assign frame_start = (refresh_cnt == '0) && (idx == '0);

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    if (HEX_EN == 0 && nib > 4'h9) s = 7'b1111111;
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      idx         <= '0;
    end else if (ref_wrap) begin
      refresh_cnt <= '0;
      idx         <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_digits   <= '0;
      sh_dp       <= '0;
      sh_blink    <= '0;
      sh_lz_en    <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      loaded      <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      frame_tick <= frame_start;
      if (frame_start) begin
        sh_digits <= digits;
        sh_dp     <= dp;
        sh_blink  <= blink_mask;
        sh_lz_en  <= lz_en;
        loaded    <= 1'b1;
        if (blink_cnt == BLK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // A digit is a leading zero when it and every digit to its left are 0.
  always_comb begin
    lz         = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (sh_digits[4*i +: 4] == 4'h0);
      lz[i]      = sh_lz_en & zero_above;
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_lz    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib   = sh_digits[4*i +: 4];
        cur_dp    = sh_dp[i];
        cur_blink = sh_blink[i];
        cur_lz    = lz[i];
      end
    end
  end

  assign cur_dec = decode(cur_nib);
  assign an_sel  = ~(NUM_DIGITS'(1) << idx);

  // Outputs stay dark until the first frame has loaded real shadow data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= 8'hFF;
      an  <= '1;
    end else if (!loaded || (cur_blink && blink_phase)) begin
      seg <= 8'hFF;
      an  <= '1;
    end else if (cur_lz) begin
      seg <= {~cur_dp, 7'h7F};
      an  <= cur_dp ? an_sel : '1;
    end else begin
      seg <= {~cur_dp, cur_dec};
      an  <= an_sel;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: drives two instances (decimal-only and hex decode)
// with shared inputs and compares every cycle against a frame-level model.
module tb_seven_seg_scan;

  localparam int N  = 4;
  localparam int R  = 4;
  localparam int BF = 2;
  localparam int FRAME = N * R;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [4*N-1:0] digits = 16'h1234;
  logic [N-1:0]   dp = '0;
  logic [N-1:0]   blink_mask = '0;
  logic           lz_en = 1'b0;
  logic [7:0]     seg_h, seg_d;
  logic [N-1:0]   an_h, an_d;
  logic           tick_h, tick_d;

  int tests = 0;
  int fails = 0;

  // model state: edges since reset release, captured frame data, frame count
  int             n = 0;
  int             frames = 0;
  logic [4*N-1:0] m_digits = '0;
  logic [N-1:0]   m_dp = '0;
  logic [N-1:0]   m_blink = '0;
  logic           m_lz = 1'b0;

  seven_seg_scan #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLINK_FRAMES(BF), .HEX_EN(1)) dut_hex (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp(dp), .blink_mask(blink_mask),
    .lz_en(lz_en), .seg(seg_h), .an(an_h), .frame_tick(tick_h));

  seven_seg_scan #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLINK_FRAMES(BF), .HEX_EN(0)) dut_dec (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp(dp), .blink_mask(blink_mask),
    .lz_en(lz_en), .seg(seg_d), .an(an_d), .frame_tick(tick_d));

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_glyph(input int v, input bit hex);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: begin
        if (!hex) return 7'h7F;
        case (v)
          10: return 7'h08; 11: return 7'h03; 12: return 7'h46;
          13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
        endcase
      end
    endcase
  endfunction

  // Expected outputs after the next edge, from the model state after n edges.
  task automatic model_out(input bit hex, output logic [7:0] s, output logic [N-1:0] a);
    int d, val, upper;
    bit phase, is_lz;
    s = 8'hFF;
    a = '1;
    if (n == 0) return;
    d     = (n / R) % N;
    phase = ((frames / BF) % 2) == 1;
    val   = int'((m_digits >> (4 * d)) & 16'hF);
    upper = int'(m_digits >> (4 * d));
    is_lz = m_lz && (d > 0) && (upper == 0);
    if (m_blink[d] && phase) return;
    if (is_lz) begin
      s = {~m_dp[d], 7'h7F};
      if (m_dp[d]) a = ~(N'(1) << d);
    end else begin
      s = {~m_dp[d], ref_glyph(val, hex)};
      a = ~(N'(1) << d);
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s n=%0d: observed %h expected %h", tag, n, obs, exp);
    end
  endtask

  task automatic step();
    logic [7:0]   es_h, es_d;
    logic [N-1:0] ea_h, ea_d;
    logic         etick;
    model_out(1'b1, es_h, ea_h);
    model_out(1'b0, es_d, ea_d);
    etick = (n % FRAME) == 0;
    if (etick) begin
      m_digits = digits;
      m_dp     = dp;
      m_blink  = blink_mask;
      m_lz     = lz_en;
      frames++;
    end
    @(posedge clk);
    #1;
    check("seg_hex", seg_h, es_h);
    check("an_hex", 8'(an_h), 8'(ea_h));
    check("tick_hex", 8'(tick_h), 8'(etick));
    check("seg_dec", seg_d, es_d);
    check("an_dec", 8'(an_d), 8'(ea_d));
    tests++;
    assert ((an_h == '1) || $onehot(~an_h)) else begin
      fails++;
      $error("FAIL an_onehot n=%0d: observed %b expected one-hot-low or all-high", n, an_h);
    end
    n++;
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic model_reset();
    n = 0;
    frames = 0;
    m_digits = '0;
    m_dp = '0;
    m_blink = '0;
    m_lz = 1'b0;
  endtask

  initial begin
    // reset values while held in reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_seg", seg_h, 8'hFF);
    check("rst_an", 8'(an_h), 8'h0F);
    check("rst_tick", 8'(tick_h), 8'h00);
    rst_n = 1'b1;
    model_reset();

    // 1234, then 5678 mid-frame: current frame keeps 1234
    steps(8);
    digits = 16'h5678;
    steps(FRAME + 12);

    // leading-zero suppression with dp on a suppressed digit
    digits = 16'h0070;
    lz_en  = 1'b1;
    dp     = 4'b1000;
    steps(2 * FRAME);

    // blink on digit 0
    digits     = 16'h4321;
    lz_en      = 1'b0;
    dp         = 4'b0100;
    blink_mask = 4'b0001;
    steps(5 * FRAME);

    // hex codes
    blink_mask = '0;
    dp         = '0;
    digits     = 16'hABCD;
    steps(2 * FRAME);

    // randomized inputs changing at arbitrary points
    for (int i = 0; i < 8 * FRAME; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        digits     = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 3)));
        dp         = 4'($urandom);
        blink_mask = 4'($urandom);
        lz_en      = 1'($urandom);
      end
      step();
    end

    // asynchronous reset mid-slot
    steps(FRAME + 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_seg", seg_h, 8'hFF);
    check("mid_rst_an", 8'(an_h), 8'h0F);
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_tick", 8'(tick_h), 8'h00);
    rst_n = 1'b1;
    model_reset();
    steps(2 * FRAME + 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
